// File: rtl/fetch.sv
// Instruction fetch stage: program-loaded synchronous instruction RAM plus an
// IDLE/RUN/HALT sequencer delivering one word-indexed instruction per cycle.
module fetch #(
    parameter int unsigned ADDR_W   = 12,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              halt,
    input  logic              stall,
    input  logic              is_jump,
    input  logic [31:0]       jump_dest,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [31:0]       prog_data,
    output logic              valid,
    output logic [31:0]       pc_out,
    output logic [31:0]       instr_raw,
    output logic [31:0]       fetch_count,
    output logic              running
);

    localparam int unsigned DEPTH = 32'd1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_e;

    state_e            state_r;
    state_e            state_next_s;

    logic [31:0]       mem_r [DEPTH];
    logic [31:0]       next_pc_r;
    logic [31:0]       pc_out_r;
    logic [31:0]       instr_raw_r;
    logic [31:0]       fetch_count_r;
    logic              valid_r;
    logic              running_r;

    logic              load_s;
    logic              clr_valid_s;
    logic              count_s;
    logic [31:0]       new_pc_s;
    logic [ADDR_W-1:0] rd_addr_s;

    // Next-state and fetch-control decode; halt outranks every other request.
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        clr_valid_s  = 1'b0;
        new_pc_s     = next_pc_r;
        case (state_r)
            IDLE: begin
                if (halt) begin
                    state_next_s = HALT;
                    clr_valid_s  = 1'b1;
                end else if (start) begin
                    state_next_s = RUN;
                    load_s       = 1'b1;
                    new_pc_s     = RESET_PC;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (halt) begin
                    state_next_s = HALT;
                    clr_valid_s  = 1'b1;
                end else if (is_jump) begin
                    load_s   = 1'b1;
                    new_pc_s = jump_dest;
                end else if (!stall) begin
                    load_s   = 1'b1;
                    new_pc_s = next_pc_r;
                end else begin
                    load_s   = 1'b0;
                end
            end
            HALT: begin
                state_next_s = HALT;
            end
            default: begin
                state_next_s = IDLE;
                clr_valid_s  = 1'b1;
            end
        endcase
    end

    // Only the low ADDR_W bits select a word, so PCs wrap modulo the depth.
    always_comb begin
        rd_addr_s = new_pc_s[ADDR_W-1:0];
        if (state_r == RUN) begin
            count_s = valid_r & ~stall;
        end else begin
            count_s = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Program write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (prog_we) begin
            mem_r[prog_addr] <= prog_data;
        end
    end

    // Read port: registered output gives old data on a same-address write.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            instr_raw_r <= 32'h0000_0000;
        end else if (load_s) begin
            instr_raw_r <= mem_r[rd_addr_s];
        end
    end

    // PC tracking and valid flag alongside the read data.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            pc_out_r  <= 32'h0000_0000;
            next_pc_r <= RESET_PC;
            valid_r   <= 1'b0;
        end else if (load_s) begin
            pc_out_r  <= new_pc_s;
            next_pc_r <= new_pc_s + 32'd1;
            valid_r   <= 1'b1;
        end else if (clr_valid_s) begin
            valid_r   <= 1'b0;
        end
    end

    // Delivered-instruction counter and registered running flag.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            fetch_count_r <= 32'h0000_0000;
            running_r     <= 1'b0;
        end else begin
            running_r <= (state_next_s == RUN);
            if (count_s) begin
                fetch_count_r <= fetch_count_r + 32'd1;
            end
        end
    end

    assign valid       = valid_r;
    assign pc_out      = pc_out_r;
    assign instr_raw   = instr_raw_r;
    assign fetch_count = fetch_count_r;
    assign running     = running_r;

endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 Parameter ADDR_W, 12: instruction memory word-address width; depth = 2**ADDR_W words of 32 bits.
REQ-002 Parameter RESET_PC, 32'h0: word-indexed PC fetched first after start.
REQ-003 clk  input  1  clock; all state updates on posedge clk.
REQ-004 rstn  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  program loader done; releases fetch from IDLE.
REQ-006 halt  input  1  controller halt request.
REQ-007 stall  input  1  downstream (decode) cannot accept; hold outputs.
REQ-008 is_jump  input  1  redirect from execute stage.
REQ-009 jump_dest  input  32  word-indexed redirect target.
REQ-010 prog_we  input  1  instruction memory write enable.
REQ-011 prog_addr  input  ADDR_W  instruction memory write word address.
REQ-012 prog_data  input  32  instruction memory write data.
REQ-013 valid  output  1  instr_raw/pc_out hold a fetched instruction.
REQ-014 pc_out  output  32  word-indexed PC of instr_raw.
REQ-015 instr_raw  output  32  fetched instruction word.
REQ-016 fetch_count  output  32  number of instructions delivered (valid & ~stall cycles).
REQ-017 running  output  1  high in state RUN.

Function
REQ-018 PCs SHALL be word indices; next sequential PC = PC+1; memory index = PC[ADDR_W-1:0] (upper bits ignored, wrap modulo depth).
REQ-019 Instruction memory SHALL be single-clock synchronous BRAM: one write port (prog_*), one read port with read enable; read data valid the cycle after the address edge.
REQ-020 FSM states SHALL be IDLE, RUN, HALT; reset enters IDLE.
REQ-021 IDLE: no reads, valid=0; on edge with start=1 -> RUN, issue read of RESET_PC, pc_out<=RESET_PC, valid<=1, next_pc<=RESET_PC+1.
REQ-022 RUN, stall=0, is_jump=0: each edge issues read of next_pc, pc_out<=next_pc, valid<=1, next_pc<=next_pc+1 (one instruction per cycle, zero bubbles).
REQ-023 RUN, stall=1, is_jump=0: read enable low, valid/pc_out/instr_raw/next_pc unchanged.
REQ-024 RUN, is_jump=1 (stall ignored): issue read of jump_dest, pc_out<=jump_dest, valid<=1, next_pc<=jump_dest+1; instruction previously on outputs discarded.
REQ-025 halt=1 in RUN or IDLE SHALL take priority over is_jump, stall, start: -> HALT, valid<=0; HALT exits only via reset.
REQ-026 fetch_count SHALL increment by 1 on each edge where valid=1 and stall=0 and state=RUN, wrapping at 2**32.
REQ-027 prog_we SHALL write at any time; read and write to same address in same cycle returns old data.
REQ-028 Memory contents SHALL NOT be cleared by reset.

Reset
REQ-029 Edge with rstn=0: state=IDLE, valid=0, pc_out=0, instr_raw=0, next_pc=RESET_PC, fetch_count=0, running=0; overrides start/halt/is_jump/stall.
REQ-030 Reset mid-RUN SHALL drop any in-flight read; first output after re-start is RESET_PC.

Verification
REQ-031 Load mem[0..3]=11,22,33,44, pulse start, stall=0 -> next four cycles pc_out=0..3, instr_raw=11,22,33,44, valid=1; fetch_count=4.
REQ-032 In RUN at pc_out=1, stall=1 for 3 cycles -> pc_out=1, instr_raw=22 held, fetch_count unchanged; stall=0 -> pc_out=2 next cycle.
REQ-033 is_jump=1, jump_dest=100, stall=1 same cycle -> next cycle pc_out=100, instr_raw=mem[100], then pc_out=101.
REQ-034 jump_dest=32'h0000_1005 with ADDR_W=12 -> instr_raw=mem[5], pc_out=32'h0000_1005; sequential from 2**ADDR_W-1 wraps to mem[0].
REQ-035 halt=1 with is_jump=1 same cycle -> valid=0, running=0 next cycle and thereafter until rstn=0.
REQ-036 rstn=0 one cycle mid-RUN at pc_out=7 -> valid=0, fetch_count=0; after start, pc_out=RESET_PC with mem contents preserved.
